// File: rtl/vx_fpu_issue_arbiter_pkg.sv
// ============================================================================
// vx_fpu_issue_arbiter_pkg : shared FPU request payload type and tag sizing
// Revision: 1.0
// ============================================================================
`default_nettype none

package vx_fpu_issue_arbiter_pkg;

    localparam int FPU_PIPE_DEPTH = 6;
    localparam int FPU_TAG_MARGIN = 2;
    // Enough tags to cover a full pipeline plus slack, rounded to a power of 2.
    localparam int FPU_TAG_WIDTH  = $clog2(FPU_PIPE_DEPTH + FPU_TAG_MARGIN);
    localparam int FPU_NUM_TAGS   = 1 << FPU_TAG_WIDTH;

    typedef struct packed {
        logic [5:0]  uuid;
        logic [1:0]  wid;
        logic [3:0]  tmask;
        logic [15:0] pc;
        logic [3:0]  op_type;
        logic [2:0]  op_mod;
        logic [7:0]  rs1_data;
        logic [7:0]  rs2_data;
        logic [7:0]  rs3_data;
        logic [3:0]  rd;
        logic        wb;
    } fpu_req_t;

    localparam int FPU_REQ_DATAW = $bits(fpu_req_t);

    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/vx_fpu_issue_arbiter_rr_arbiter.sv
// ============================================================================
// vx_fpu_issue_arbiter_rr_arbiter : round-robin arbiter with grant lock
// Revision: 1.0
// ============================================================================
`default_nettype none

module vx_fpu_issue_arbiter_rr_arbiter
    import vx_fpu_issue_arbiter_pkg::*;
#(
    parameter int NUM_REQS     = 4,
    parameter int REQ_IDX_BITS = $clog2(NUM_REQS)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_REQS-1:0]     requests_i,
    input  logic                    lock_i,
    input  logic [REQ_IDX_BITS-1:0] lock_idx_i,
    input  logic                    advance_i,
    output logic [NUM_REQS-1:0]     grant_onehot_o,
    output logic [REQ_IDX_BITS-1:0] grant_idx_o,
    output logic                    grant_valid_o
);

    logic [REQ_IDX_BITS-1:0] ptr_q, ptr_d;
    logic [REQ_IDX_BITS-1:0] w_rr_idx;
    logic                    w_rr_found;

    always_comb begin
        int j;
        j          = 0;
        w_rr_idx   = '0;
        w_rr_found = 1'b0;
        for (int k = 0; k < NUM_REQS; k++) begin
            j = int'(ptr_q) + k;
            if (j >= NUM_REQS) j = j - NUM_REQS;
            if (!w_rr_found && requests_i[j]) begin
                w_rr_idx   = REQ_IDX_BITS'(j);
                w_rr_found = 1'b1;
            end
        end
    end

    assign grant_idx_o    = lock_i ? lock_idx_i : w_rr_idx;
    assign grant_valid_o  = lock_i ? requests_i[lock_idx_i] : w_rr_found;
    assign grant_onehot_o = grant_valid_o ? (NUM_REQS'(1) << grant_idx_o) : '0;

    always_comb begin
        ptr_d = ptr_q;
        if (advance_i) ptr_d = REQ_IDX_BITS'(wrap_inc(int'(grant_idx_o), NUM_REQS));
    end

    always_ff @(posedge clk) begin
        if (reset) ptr_q <= '0;
        else       ptr_q <= ptr_d;
    end

endmodule

`default_nettype wire

// File: rtl/vx_fpu_issue_arbiter.sv
// ============================================================================
// vx_fpu_issue_arbiter : shares one FPU request port among issue requesters,
//                        tagging each request and routing responses back.
// Revision: 1.0
// ============================================================================
`default_nettype none

module vx_fpu_issue_arbiter
    import vx_fpu_issue_arbiter_pkg::*;
#(
    parameter int NUM_REQS     = 4,
    parameter int REQ_DATAW    = FPU_REQ_DATAW,
    parameter int NUM_TAGS     = FPU_NUM_TAGS,
    parameter int TAG_BITS     = $clog2(NUM_TAGS),
    parameter int REQ_IDX_BITS = $clog2(NUM_REQS)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQS-1:0]           req_valid_in,
    input  logic [NUM_REQS*REQ_DATAW-1:0] req_data_in,
    output logic [NUM_REQS-1:0]           req_ready_in,
    output logic                          fpu_req_valid,
    output logic [REQ_DATAW-1:0]          fpu_req_data,
    output logic [TAG_BITS-1:0]           fpu_req_tag,
    input  logic                          fpu_req_ready,
    input  logic                          fpu_rsp_valid,
    input  logic [TAG_BITS-1:0]           fpu_rsp_tag,
    output logic                          fpu_rsp_ready,
    output logic                          rsp_valid,
    output logic [REQ_IDX_BITS-1:0]       rsp_req_idx,
    input  logic                          rsp_ready_in,
    output logic [TAG_BITS:0]             pending_count,
    output logic                          busy
);

    logic [NUM_TAGS-1:0]     used_q, used_d;
    logic [REQ_IDX_BITS-1:0] table_q [NUM_TAGS];
    logic [TAG_BITS:0]       pending_q, pending_d;
    logic                    lock_q, lock_d;
    logic [REQ_IDX_BITS-1:0] lock_idx_q, lock_idx_d;
    logic [TAG_BITS-1:0]     lock_tag_q, lock_tag_d;

    logic                    w_free_exists;
    logic [TAG_BITS-1:0]     w_free_tag;
    logic [TAG_BITS-1:0]     w_tag;
    logic [NUM_REQS-1:0]     w_grant_onehot;
    logic [REQ_IDX_BITS-1:0] w_grant_idx;
    logic                    w_grant_valid;
    logic                    w_req_fire;
    logic                    w_rsp_fire;

    vx_fpu_issue_arbiter_rr_arbiter #(
        .NUM_REQS     (NUM_REQS),
        .REQ_IDX_BITS (REQ_IDX_BITS)
    ) u_rr_arbiter (
        .clk            (clk),
        .reset          (reset),
        .requests_i     (req_valid_in),
        .lock_i         (lock_q),
        .lock_idx_i     (lock_idx_q),
        .advance_i      (w_req_fire),
        .grant_onehot_o (w_grant_onehot),
        .grant_idx_o    (w_grant_idx),
        .grant_valid_o  (w_grant_valid)
    );

    always_comb begin
        w_free_tag = '0;
        for (int t = NUM_TAGS - 1; t >= 0; t--) begin
            if (!used_q[t]) w_free_tag = TAG_BITS'(t);
        end
    end

    // A tag released this cycle only clears used_q at the next edge, so a full
    // table blocks issue even while a response is retiring.
    assign w_free_exists = ~&used_q;
    assign w_tag         = lock_q ? lock_tag_q : w_free_tag;

    assign fpu_req_valid = (|req_valid_in) && w_free_exists && !reset;
    assign fpu_req_data  = req_data_in[w_grant_idx*REQ_DATAW +: REQ_DATAW];
    assign fpu_req_tag   = w_tag;
    assign req_ready_in  = w_grant_onehot & {NUM_REQS{fpu_req_ready && w_free_exists && !reset}};
    assign w_req_fire    = fpu_req_valid && fpu_req_ready;

    assign fpu_rsp_ready = rsp_ready_in;
    assign rsp_valid     = fpu_rsp_valid;
    assign rsp_req_idx   = table_q[fpu_rsp_tag];
    assign w_rsp_fire    = fpu_rsp_valid && rsp_ready_in && used_q[fpu_rsp_tag];

    assign pending_count = pending_q;
    assign busy          = (pending_q != '0) || fpu_req_valid;

    always_comb begin
        used_d     = used_q;
        pending_d  = pending_q;
        lock_d     = lock_q;
        lock_idx_d = lock_idx_q;
        lock_tag_d = lock_tag_q;
        if (w_rsp_fire) used_d[fpu_rsp_tag] = 1'b0;
        if (w_req_fire) used_d[w_tag] = 1'b1;
        case ({w_req_fire, w_rsp_fire})
            2'b10:   pending_d = pending_q + 1'b1;
            2'b01:   pending_d = pending_q - 1'b1;
            default: pending_d = pending_q;
        endcase
        if (w_req_fire) begin
            lock_d = 1'b0;
        end else if (fpu_req_valid && !lock_q) begin
            lock_d     = 1'b1;
            lock_idx_d = w_grant_idx;
            lock_tag_d = w_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            used_q     <= '0;
            pending_q  <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
            lock_tag_q <= '0;
        end else begin
            used_q     <= used_d;
            pending_q  <= pending_d;
            lock_q     <= lock_d;
            lock_idx_q <= lock_idx_d;
            lock_tag_q <= lock_tag_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_req_fire) table_q[w_tag] <= w_grant_idx;
    end

    a_lock_hold: assert property (@(posedge clk) disable iff (reset)
        lock_q |-> (req_valid_in[lock_idx_q] && $stable(fpu_req_data)));

    a_rsp_tag_in_use: assert property (@(posedge clk) disable iff (reset)
        (fpu_rsp_valid && rsp_ready_in) |-> used_q[fpu_rsp_tag]);

endmodule

`default_nettype wire

// File: doc/vx_fpu_issue_arbiter.md
Name: vx_fpu_issue_arbiter

Overview:
- Shares one FPU request port between NUM_REQS issue requesters; each requester carries a packed FPU request payload (uuid, wid, tmask, PC, op_type, op_mod, rs1/2/3 data, rd, wb).
- Round-robin arbitration; allocates a per-request tag from a fixed pool, bounding FPU occupancy to NUM_TAGS.
- Returns the originating requester index with each FPU response.
- Sits between the per-warp issue slots and the FPU unit's slave request port.

Parameters:
- NUM_REQS, 4, number of requesters (>=2).
- REQ_DATAW, 64, packed request payload width per requester.
- NUM_TAGS, 8, max in-flight FPU operations (power of 2).
- TAG_BITS, $clog2(NUM_TAGS), derived; not overridden.
- REQ_IDX_BITS, $clog2(NUM_REQS), derived.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous active-high reset.
- req_valid_in  in  NUM_REQS  per-requester valid.
- req_data_in  in  NUM_REQS*REQ_DATAW  per-requester payload, requester i at slice i.
- req_ready_in  out  NUM_REQS  per-requester ready.
- fpu_req_valid  out  1  request to FPU.
- fpu_req_data  out  REQ_DATAW  granted payload.
- fpu_req_tag  out  TAG_BITS  allocated tag.
- fpu_req_ready  in  1  FPU accepts.
- fpu_rsp_valid  in  1  FPU completion.
- fpu_rsp_tag  in  TAG_BITS  completing tag.
- fpu_rsp_ready  out  1  = rsp_ready_in.
- rsp_valid  out  1  = fpu_rsp_valid.
- rsp_req_idx  out  REQ_IDX_BITS  requester that issued fpu_rsp_tag.
- rsp_ready_in  in  1  downstream accepts response.
- pending_count  out  TAG_BITS+1  tags in use.
- busy  out  1  pending_count != 0 or fpu_req_valid.

Behaviour:
- Reset (synchronous, active-high): all tags free, RR pointer = 0, lock cleared, pending_count = 0. fpu_req_valid, req_ready_in and busy read 0 in the cycle after reset is sampled.
- Arbitration is combinational (zero latency). Priority starts at the RR pointer and wraps modulo NUM_REQS.
- On an fpu_req handshake the pointer advances to (grant+1) mod NUM_REQS.
- Tag choice: lowest-index free tag.
- fpu_req_valid = (any req_valid_in) && (free tag exists).
- req_ready_in[i] = grant[i] && fpu_req_ready && free tag exists. Only one bit is high at a time.
- Lock rule: if fpu_req_valid=1 and fpu_req_ready=0, register the grant index and tag. While locked, grant and tag hold, even if a higher-priority requester arrives or a lower tag frees. The lock clears on handshake.
- A requester must hold valid and data until ready. Violation while locked is an assertion failure.
- On handshake: mark the tag used and store the grant index in the tag table (NUM_TAGS x REQ_IDX_BITS); pending_count increments.
- On a response handshake (fpu_rsp_valid && rsp_ready_in): rsp_req_idx = table[fpu_rsp_tag] combinationally. The tag frees next cycle; pending_count decrements.
- Same-cycle alloc and free: pending_count is unchanged. The freed tag is not reusable in the same cycle (no bypass).
- Full (pending_count == NUM_TAGS): fpu_req_valid = 0 and all req_ready_in = 0, even if a response frees a tag that cycle.
- Response with a tag not in use: assertion error; table and count are unchanged.
- Reset mid-operation: all in-flight tags are discarded. Responses arriving after reset for pre-reset tags are illegal.

Decomposition:
- Shared package (VX_gpu_pkg): fpu_req_t packed struct for the payload; the FPU tag width constant, derived from the pipeline depth plus margin.
- Sub-module: VX_rr_arbiter (NUM_REQS, lock input, one-hot grant plus index).
- Tag free-list, lock register and index table stay inline.

Test Plan:
- Single requester: req 2 valid with data 0xA5, FPU ready → handshake in the same cycle, tag 0, pending_count 1. Response tag 0 → rsp_req_idx 2, pending_count 0.
- All 4 requesters valid continuously, FPU always ready, responses every cycle → grants 0,1,2,3,0… with tags cycling, no starvation.
- Requesters 1 and 3 valid, FPU ready low 5 cycles, requester 0 asserts on cycle 2 → grant stays 1 with the same tag until ready. The next grant is 3, then 0.
- 8 issues with no responses → pending_count 8, fpu_req_valid 0. Response tag 5 in the same cycle as a request → no grant that cycle. Next cycle the grant takes tag 5.
- Out-of-order responses on tags 3, 0, 6 → correct rsp_req_idx for each. The next allocation takes lowest free tag 0.
- Reset asserted with 4 in flight and a locked request → next cycle pending_count 0, fpu_req_valid 0, pointer 0. The first post-reset grant uses tag 0.
